// File: rtl/dcache_pkg.sv
// Shared types and helpers for the fully-associative write-back data cache.
package dcache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EVICT,
    FILL_REQ,
    FILL,
    RESPOND,
    FLUSH_SCAN,
    FLUSH_WB
  } state_t;

  localparam logic [1:0] WL_BYTE = 2'b00;
  localparam logic [1:0] WL_HALF = 2'b01;
  localparam logic [1:0] WL_WORD = 2'b10;

  // Byte lanes touched by an access; 11 behaves as a word.
  function automatic logic [3:0] byte_en(input logic [1:0] wordlen, input logic [1:0] lane);
    case (wordlen)
      WL_BYTE: byte_en = 4'b0001 << lane;
      WL_HALF: byte_en = lane[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  // Replicate right-aligned write data onto every lane so the byte enables pick it up.
  function automatic logic [31:0] align_wdata(input logic [31:0] data, input logic [1:0] wordlen);
    case (wordlen)
      WL_BYTE: align_wdata = {4{data[7:0]}};
      WL_HALF: align_wdata = {2{data[15:0]}};
      default: align_wdata = data;
    endcase
  endfunction

  // Select the addressed byte/half/word and zero-extend it.
  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] wordlen,
                                          input logic [1:0] lane);
    logic [31:0] sh_b;
    logic [31:0] sh_h;
    sh_b = word >> {lane, 3'b000};
    sh_h = word >> {lane[1], 4'b0000};
    case (wordlen)
      WL_BYTE: extract = {24'h0, sh_b[7:0]};
      WL_HALF: extract = {16'h0, sh_h[15:0]};
      default: extract = word;
    endcase
  endfunction

endpackage

// File: rtl/dcache_way.sv
// One cache line: tag/valid/dirty plus WORDS data words with CPU, fill and read ports.
module dcache_way #(
  parameter int DATABITS = 32,
  parameter int TAGBITS  = 27,
  parameter int WORDS    = 8,
  parameter int IDXB     = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [TAGBITS-1:0]    lookup_tag,
  output logic                  hit,
  output logic                  valid,
  output logic                  dirty,
  output logic [TAGBITS-1:0]    tag,
  input  logic                  cpu_we,
  input  logic [IDXB-1:0]       cpu_idx,
  input  logic [DATABITS/8-1:0] cpu_be,
  input  logic [DATABITS-1:0]   cpu_wdata,
  input  logic                  fill_we,
  input  logic [IDXB-1:0]       fill_idx,
  input  logic [DATABITS-1:0]   fill_wdata,
  input  logic                  fill_last,
  input  logic [TAGBITS-1:0]    fill_tag,
  input  logic                  clean,
  input  logic [IDXB-1:0]       rd_idx,
  output logic [DATABITS-1:0]   rd_data
);

  logic [DATABITS-1:0] data [WORDS];

  assign hit     = valid && (tag == lookup_tag);
  assign rd_data = data[rd_idx];

  // Line status: the last fill word installs the tag; CPU writes mark dirty; flush cleans.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      dirty <= 1'b0;
      tag   <= '0;
    end else if (fill_we && fill_last) begin
      valid <= 1'b1;
      dirty <= 1'b0;
      tag   <= fill_tag;
    end else if (cpu_we) begin
      dirty <= 1'b1;
    end else if (clean) begin
      dirty <= 1'b0;
    end
  end

  // Data storage: whole-word fills, byte-enabled CPU writes. Contents only matter once valid.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data[fill_idx] <= fill_wdata;
    end else if (cpu_we) begin
      for (int b = 0; b < DATABITS / 8; b++) begin
        if (cpu_be[b]) data[cpu_idx][8*b +: 8] <= cpu_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/dcache_assoc.sv
// Fully-associative write-back data cache with round-robin replacement and explicit flush.
module dcache_assoc
  import dcache_pkg::*;
#(
  parameter int DATABITS = 32,
  parameter int ADDRBITS = 32,
  parameter int LINENUM  = 4,
  parameter int WORDS    = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDRBITS-1:0] dcache_addr,
  input  logic [DATABITS-1:0] dcache_in,
  input  logic                dcache_rdreq,
  input  logic                dcache_wrreq,
  input  logic [1:0]          dcache_wordlen,
  output logic [DATABITS-1:0] dcache_out,
  output logic                dcache_out_valid,
  output logic                dcache_ready,
  input  logic                dcache_flush,
  output logic                dcache_flush_done,
  output logic [ADDRBITS-1:0] mem_addr,
  output logic [DATABITS-1:0] mem_in,
  output logic                mem_wrreq,
  input  logic                mem_wr_ack,
  output logic                mem_rdreq,
  input  logic [DATABITS-1:0] mem_out,
  input  logic                mem_out_valid,
  output logic [15:0]         mem_burstlen
);

  localparam int OFFS    = $clog2(WORDS * 4);
  localparam int TAGBITS = ADDRBITS - OFFS;
  localparam int IDXB    = $clog2(WORDS);
  localparam int LB      = (LINENUM > 1) ? $clog2(LINENUM) : 1;
  localparam logic [IDXB-1:0] LAST_WORD = IDXB'(WORDS - 1);
  localparam logic [LB-1:0]   LAST_LINE = LB'(LINENUM - 1);

  state_t              state;
  logic [LB-1:0]       rr_ptr, victim, scan, hit_line;
  logic [IDXB-1:0]     k;
  logic [ADDRBITS-1:0] req_addr;
  logic [DATABITS-1:0] req_data;
  logic [1:0]          req_wl;
  logic                req_wr;
  logic                hit_any;

  logic [LINENUM-1:0]  way_hit, way_valid, way_dirty, cpu_we, fill_we, clean;
  logic [TAGBITS-1:0]  way_tag [LINENUM];
  logic [DATABITS-1:0] way_rd  [LINENUM];

  // In IDLE the live CPU request drives the line ports; afterwards the latched one does.
  logic                idle;
  logic [ADDRBITS-1:0] sel_addr;
  logic [1:0]          sel_wl;
  logic [IDXB-1:0]     sel_idx, rd_idx;
  logic [TAGBITS-1:0]  cur_tag, req_tag;
  logic [3:0]          cpu_be;
  logic [DATABITS-1:0] cpu_wdata, hit_rd, vic_rd, fill_rd;

  assign idle      = (state == IDLE);
  assign sel_addr  = idle ? dcache_addr : req_addr;
  assign sel_wl    = idle ? dcache_wordlen : req_wl;
  assign sel_idx   = sel_addr[OFFS-1:2];
  assign cur_tag   = dcache_addr[ADDRBITS-1:OFFS];
  assign req_tag   = req_addr[ADDRBITS-1:OFFS];
  assign cpu_be    = byte_en(sel_wl, sel_addr[1:0]);
  assign cpu_wdata = align_wdata(idle ? dcache_in : req_data, sel_wl);
  assign rd_idx    = (state == EVICT || state == FLUSH_WB) ? k : sel_idx;
  assign hit_rd    = way_rd[hit_line];
  assign vic_rd    = way_rd[victim];
  // The requested word may arrive on the very last fill beat, before it is stored.
  assign fill_rd   = (req_addr[OFFS-1:2] == k) ? mem_out : vic_rd;

  assign mem_in       = mem_wrreq ? vic_rd : '0;
  assign mem_burstlen = 16'(WORDS);

  for (genvar i = 0; i < LINENUM; i++) begin : g_way
    assign cpu_we[i]  = (idle && dcache_wrreq && way_hit[i]) ||
                        (state == RESPOND && req_wr && victim == LB'(i));
    assign fill_we[i] = (state == FILL) && mem_out_valid && (victim == LB'(i));
    assign clean[i]   = (state == FLUSH_WB) && mem_wr_ack && (k == LAST_WORD) && (victim == LB'(i));

    dcache_way #(.DATABITS(DATABITS), .TAGBITS(TAGBITS), .WORDS(WORDS), .IDXB(IDXB)) u_way (
      .clk       (clk),
      .rst_n     (reset_n),
      .lookup_tag(cur_tag),
      .hit       (way_hit[i]),
      .valid     (way_valid[i]),
      .dirty     (way_dirty[i]),
      .tag       (way_tag[i]),
      .cpu_we    (cpu_we[i]),
      .cpu_idx   (sel_idx),
      .cpu_be    (cpu_be),
      .cpu_wdata (cpu_wdata),
      .fill_we   (fill_we[i]),
      .fill_idx  (k),
      .fill_wdata(mem_out),
      .fill_last (k == LAST_WORD),
      .fill_tag  (req_tag),
      .clean     (clean[i]),
      .rd_idx    (rd_idx),
      .rd_data   (way_rd[i])
    );
  end

  // Encode the (at most one) hitting line.
  always_comb begin
    hit_line = '0;
    hit_any  = 1'b0;
    for (int i = 0; i < LINENUM; i++) begin
      if (way_hit[i]) begin
        hit_line = LB'(i);
        hit_any  = 1'b1;
      end
    end
  end

  // Controller: hit service, miss eviction/fill, flush scan; all outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      rr_ptr            <= '0;
      victim            <= '0;
      scan              <= '0;
      k                 <= '0;
      req_addr          <= '0;
      req_data          <= '0;
      req_wl            <= '0;
      req_wr            <= 1'b0;
      dcache_ready      <= 1'b1;
      dcache_out        <= '0;
      dcache_out_valid  <= 1'b0;
      dcache_flush_done <= 1'b0;
      mem_addr          <= '0;
      mem_wrreq         <= 1'b0;
      mem_rdreq         <= 1'b0;
    end else begin
      dcache_out_valid  <= 1'b0;
      dcache_flush_done <= 1'b0;
      mem_rdreq         <= 1'b0;
      case (state)
        IDLE: begin
          if (dcache_rdreq || dcache_wrreq) begin
            if (hit_any) begin
              if (!dcache_wrreq) begin
                dcache_out       <= extract(hit_rd, dcache_wordlen, dcache_addr[1:0]);
                dcache_out_valid <= 1'b1;
              end
            end else begin
              req_addr     <= dcache_addr;
              req_data     <= dcache_in;
              req_wl       <= dcache_wordlen;
              req_wr       <= dcache_wrreq;
              victim       <= rr_ptr;
              k            <= '0;
              dcache_ready <= 1'b0;
              if (way_valid[rr_ptr] && way_dirty[rr_ptr]) begin
                state     <= EVICT;
                mem_wrreq <= 1'b1;
                mem_addr  <= {way_tag[rr_ptr], {OFFS{1'b0}}};
              end else begin
                state     <= FILL_REQ;
                mem_rdreq <= 1'b1;
                mem_addr  <= {cur_tag, {OFFS{1'b0}}};
              end
            end
          end else if (dcache_flush) begin
            state        <= FLUSH_SCAN;
            scan         <= '0;
            dcache_ready <= 1'b0;
          end
        end
        EVICT, FLUSH_WB: begin
          if (mem_wr_ack) begin
            if (k == LAST_WORD) begin
              k         <= '0;
              mem_wrreq <= 1'b0;
              if (state == EVICT) begin
                state     <= FILL_REQ;
                mem_rdreq <= 1'b1;
                mem_addr  <= {req_tag, {OFFS{1'b0}}};
              end else if (scan == LAST_LINE) begin
                state             <= IDLE;
                dcache_ready      <= 1'b1;
                dcache_flush_done <= 1'b1;
              end else begin
                state <= FLUSH_SCAN;
                scan  <= scan + 1'b1;
              end
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        FILL_REQ: begin
          state <= FILL;
          k     <= '0;
        end
        FILL: begin
          if (mem_out_valid) begin
            if (k == LAST_WORD) begin
              state  <= RESPOND;
              rr_ptr <= (rr_ptr == LAST_LINE) ? '0 : rr_ptr + 1'b1;
              if (!req_wr) begin
                dcache_out       <= extract(fill_rd, req_wl, req_addr[1:0]);
                dcache_out_valid <= 1'b1;
              end
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        RESPOND: begin
          state        <= IDLE;
          dcache_ready <= 1'b1;
        end
        FLUSH_SCAN: begin
          if (way_valid[scan] && way_dirty[scan]) begin
            state     <= FLUSH_WB;
            victim    <= scan;
            k         <= '0;
            mem_wrreq <= 1'b1;
            mem_addr  <= {way_tag[scan], {OFFS{1'b0}}};
          end else if (scan == LAST_LINE) begin
            state             <= IDLE;
            dcache_ready      <= 1'b1;
            dcache_flush_done <= 1'b1;
          end else begin
            scan <= scan + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_assoc.sv
// Scoreboard bench for dcache_assoc: reference cache/memory model, memory responder, read monitor.
module tb_dcache_assoc;
  localparam int LN = 4;
  localparam int WD = 8;
  localparam int WR_DELAY = 3;

  logic        clk, reset_n;
  logic [31:0] dcache_addr, dcache_in, dcache_out, mem_addr, mem_in, mem_out;
  logic        dcache_rdreq, dcache_wrreq, dcache_out_valid, dcache_ready;
  logic        dcache_flush, dcache_flush_done, mem_wrreq, mem_wr_ack, mem_rdreq, mem_out_valid;
  logic [1:0]  dcache_wordlen;
  logic [15:0] mem_burstlen;

  dcache_assoc #(.DATABITS(32), .ADDRBITS(32), .LINENUM(LN), .WORDS(WD)) dut (
    .clk(clk), .reset_n(reset_n), .dcache_addr(dcache_addr), .dcache_in(dcache_in),
    .dcache_rdreq(dcache_rdreq), .dcache_wrreq(dcache_wrreq), .dcache_wordlen(dcache_wordlen),
    .dcache_out(dcache_out), .dcache_out_valid(dcache_out_valid), .dcache_ready(dcache_ready),
    .dcache_flush(dcache_flush), .dcache_flush_done(dcache_flush_done), .mem_addr(mem_addr),
    .mem_in(mem_in), .mem_wrreq(mem_wrreq), .mem_wr_ack(mem_wr_ack), .mem_rdreq(mem_rdreq),
    .mem_out(mem_out), .mem_out_valid(mem_out_valid), .mem_burstlen(mem_burstlen)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference state: CPU-visible memory, backing memory, and which lines the cache holds.
  logic [31:0] gold   [int unsigned];
  logic [31:0] mstore [int unsigned];
  int unsigned slot_tag   [LN];
  bit          slot_valid [LN];
  bit          slot_dirty [LN];
  int          rr = 0;

  logic [31:0] sb_q[$];
  logic [31:0] fill_q[$];
  logic [31:0] wb_addr_q[$];
  logic [31:0] wb_data_q[$];
  int          fill_words_sent = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input int unsigned a);
    return (a & ~32'h1F) + ((a >> 2) & 32'h7);
  endfunction

  function automatic logic [31:0] gold_rd(input int unsigned a);
    int unsigned wa = a & ~32'h3;
    return gold.exists(wa) ? gold[wa] : init_val(wa);
  endfunction

  function automatic logic [31:0] mem_rd(input int unsigned a);
    int unsigned wa = a & ~32'h3;
    return mstore.exists(wa) ? mstore[wa] : init_val(wa);
  endfunction

  function automatic logic [31:0] model_read(input int unsigned a, input logic [1:0] wl);
    logic [31:0] w = gold_rd(a);
    if (wl == 2'b00) return (w >> (8 * (a % 4))) & 32'hFF;
    if (wl == 2'b01) return (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    return w;
  endfunction

  task automatic model_write(input int unsigned a, input logic [1:0] wl, input logic [31:0] d);
    logic [31:0] mask, val;
    if (wl == 2'b00) begin
      mask = 32'hFF << (8 * (a % 4));
      val  = (d & 32'hFF) << (8 * (a % 4));
    end else if (wl == 2'b01) begin
      mask = 32'hFFFF << (16 * ((a / 2) % 2));
      val  = (d & 32'hFFFF) << (16 * ((a / 2) % 2));
    end else begin
      mask = 32'hFFFF_FFFF;
      val  = d;
    end
    gold[a & ~32'h3] = (gold_rd(a) & ~mask) | val;
  endtask

  task automatic push_wb(input int s);
    int unsigned base = slot_tag[s] * 32;
    wb_addr_q.push_back(base);
    for (int j = 0; j < WD; j++) wb_data_q.push_back(gold_rd(base + 4 * j));
  endtask

  // Returns the slot that holds the line after the access (filling it on a miss).
  task automatic model_line(input int unsigned a, output int s);
    int unsigned t = a / 32;
    s = -1;
    for (int i = 0; i < LN; i++) if (slot_valid[i] && slot_tag[i] == t) s = i;
    if (s < 0) begin
      s = rr;
      if (slot_valid[s] && slot_dirty[s]) push_wb(s);
      fill_q.push_back(t * 32);
      slot_tag[s]   = t;
      slot_valid[s] = 1'b1;
      slot_dirty[s] = 1'b0;
      rr = (rr + 1) % LN;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < LN; i++) begin
      slot_valid[i] = 1'b0;
      slot_dirty[i] = 1'b0;
    end
    rr = 0;
    gold = mstore;
    sb_q.delete();
    fill_q.delete();
    wb_addr_q.delete();
    wb_data_q.delete();
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 500; n++) begin
      if (dcache_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: dcache_ready=0 after 500 cycles, expected 1");
    end
  endtask

  task automatic cpu_access(input logic [31:0] a, input logic [1:0] wl, input bit rd, input bit wr,
                            input logic [31:0] d);
    bit ok;
    int s;
    wait_ready(ok);
    if (!ok) return;
    model_line(a, s);
    if (wr) begin
      model_write(a, wl, d);
      slot_dirty[s] = 1'b1;
    end else begin
      sb_q.push_back(model_read(a, wl));
    end
    dcache_addr    = a;
    dcache_wordlen = wl;
    dcache_in      = d;
    dcache_rdreq   = rd;
    dcache_wrreq   = wr;
    @(negedge clk);
    dcache_rdreq = 1'b0;
    dcache_wrreq = 1'b0;
  endtask

  task automatic do_flush();
    bit ok;
    int ndirty = 0;
    int n;
    wait_ready(ok);
    if (!ok) return;
    for (int s = 0; s < LN; s++) begin
      if (slot_valid[s] && slot_dirty[s]) begin
        push_wb(s);
        slot_dirty[s] = 1'b0;
        ndirty++;
      end
    end
    dcache_flush = 1'b1;
    @(negedge clk);
    dcache_flush = 1'b0;
    n = 1;
    while (!dcache_flush_done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("flush_done", {31'b0, dcache_flush_done}, 32'd1);
    if (ndirty == 0) chk("flush_latency", n, LN + 1);
  endtask

  // Read-data monitor: every dcache_out_valid pulse consumes one expected value.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && dcache_out_valid) begin
        if (sb_q.size() == 0) chk("unexpected_read_pulse", {31'b0, dcache_out_valid}, 32'd0);
        else chk("read_data", dcache_out, sb_q.pop_front());
      end
    end
  end

  // Memory controller model: read bursts with random gaps, write bursts acked after a delay.
  initial begin
    bit          rd_active = 0, wr_active = 0, word_new = 0;
    int          rd_k = 0, rd_wait = 0, wr_k = 0, wr_wait = 0;
    logic [31:0] rd_base = 0, wr_base = 0, held = 0;
    mem_out_valid = 1'b0;
    mem_wr_ack    = 1'b0;
    mem_out       = '0;
    forever begin
      @(negedge clk);
      mem_out_valid = 1'b0;
      mem_wr_ack    = 1'b0;
      if (!reset_n) begin
        rd_active = 0;
        wr_active = 0;
        continue;
      end
      if (mem_rdreq) begin
        if (fill_q.size() == 0) chk("unexpected_rdreq", {31'b0, mem_rdreq}, 32'd0);
        else chk("fill_addr", mem_addr, fill_q.pop_front());
        chk("burstlen", {16'b0, mem_burstlen}, WD);
        rd_active = 1;
        rd_base = mem_addr;
        rd_k = 0;
        fill_words_sent = 0;
        rd_wait = $urandom_range(0, 2);
      end else if (rd_active) begin
        if (rd_wait > 0) rd_wait--;
        else begin
          mem_out = mem_rd(rd_base + 4 * rd_k);
          mem_out_valid = 1'b1;
          rd_k++;
          fill_words_sent = rd_k;
          rd_wait = $urandom_range(0, 1);
          if (rd_k == WD) rd_active = 0;
        end
      end
      if (mem_wrreq) begin
        if (!wr_active) begin
          wr_active = 1;
          wr_k = 0;
          wr_wait = WR_DELAY;
          word_new = 1;
          wr_base = mem_addr;
          if (wb_addr_q.size() == 0) chk("unexpected_wrreq", {31'b0, mem_wrreq}, 32'd0);
          else chk("wb_addr", mem_addr, wb_addr_q.pop_front());
        end else begin
          chk("wb_addr_hold", mem_addr, wr_base);
        end
        if (word_new) begin
          held = mem_in;
          word_new = 0;
        end else begin
          chk("wb_data_hold", mem_in, held);
        end
        if (wr_wait > 0) wr_wait--;
        else begin
          if (wb_data_q.size() == 0) chk("wb_extra_word", wr_k, WD);
          else chk("wb_data", mem_in, wb_data_q.pop_front());
          mstore[wr_base + 4 * wr_k] = mem_in;
          mem_wr_ack = 1'b1;
          wr_k++;
          wr_wait = WR_DELAY;
          word_new = 1;
          if (wr_k == WD) wr_active = 0;
        end
      end
    end
  end

  initial begin
    bit ok;
    int r;
    logic [31:0] a;
    reset_n = 1'b0;
    dcache_addr = '0;
    dcache_in = '0;
    dcache_rdreq = 1'b0;
    dcache_wrreq = 1'b0;
    dcache_wordlen = 2'b10;
    dcache_flush = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, dcache_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, dcache_out_valid}, 32'd0);
    chk("rst_flush_done", {31'b0, dcache_flush_done}, 32'd0);
    chk("rst_mem_wrreq", {31'b0, mem_wrreq}, 32'd0);
    chk("rst_mem_rdreq", {31'b0, mem_rdreq}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_in", mem_in, 32'd0);
    chk("rst_dcache_out", dcache_out, 32'd0);
    chk("rst_burstlen", {16'b0, mem_burstlen}, WD);
    reset_n = 1'b1;
    @(negedge clk);

    // Cold fill, then back-to-back hits and a write/read pair.
    cpu_access(32'h104, 2'b10, 1, 0, 0);
    cpu_access(32'h107, 2'b00, 1, 0, 0);
    cpu_access(32'h106, 2'b01, 1, 0, 0);
    cpu_access(32'h108, 2'b10, 0, 1, 32'hDEADBEEF);
    cpu_access(32'h108, 2'b10, 1, 0, 0);
    cpu_access(32'h100, 2'b10, 0, 1, 32'h11223344);
    cpu_access(32'h101, 2'b00, 0, 1, 32'h000000AA);
    cpu_access(32'h100, 2'b10, 1, 0, 0);
    wait_ready(ok);
    chk("byte_merge", dcache_out, 32'h1122AA44);

    // Four more lines: the last evicts the dirty first line.
    cpu_access(32'h204, 2'b10, 1, 0, 0);
    cpu_access(32'h300, 2'b10, 1, 0, 0);
    cpu_access(32'h400, 2'b10, 1, 0, 0);
    cpu_access(32'h500, 2'b10, 1, 0, 0);
    cpu_access(32'h100, 2'b10, 1, 0, 0);

    // Two dirty lines flushed in index order, then an empty flush.
    cpu_access(32'h504, 2'b10, 0, 1, 32'hCAFE0001);
    cpu_access(32'h30A, 2'b01, 0, 1, 32'h0000BEEF);
    do_flush();
    do_flush();

    // Randomized traffic over six lines, including combined rd/wr and flushes.
    for (int i = 0; i < 400; i++) begin
      a = 32'h1000 + 32 * $urandom_range(0, 5) + $urandom_range(0, 31);
      r = $urandom_range(0, 99);
      if (r < 45) cpu_access(a, 2'($urandom_range(0, 3)), 1, 0, 0);
      else if (r < 85) cpu_access(a, 2'($urandom_range(0, 3)), 0, 1, $urandom);
      else if (r < 95) cpu_access(a, 2'($urandom_range(0, 3)), 1, 1, $urandom);
      else do_flush();
    end
    do_flush();
    wait_ready(ok);
    repeat (5) @(negedge clk);

    // Reset during a fill; the same address must miss again afterwards.
    cpu_access(32'h2004, 2'b10, 1, 0, 0);
    r = 0;
    while (fill_words_sent != 3 && r < 200) begin
      @(negedge clk);
      #2;
      r++;
    end
    chk("reset_fill_reached", fill_words_sent, 3);
    reset_n = 1'b0;
    #1;
    chk("reset_ready", {31'b0, dcache_ready}, 32'd1);
    chk("reset_rdreq", {31'b0, mem_rdreq}, 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    cpu_access(32'h2004, 2'b10, 1, 0, 0);
    wait_ready(ok);
    repeat (5) @(negedge clk);

    chk("sb_drained", sb_q.size(), 0);
    chk("fill_drained", fill_q.size(), 0);
    chk("wb_drained", wb_addr_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_assoc.md
Name: dcache_assoc

Overview:
Parametrised, fully-associative, write-back data cache between the CPU core and the memory controller. It replaces the fixed four-line arrangement with LINENUM lines of WORDS words each and round-robin replacement. Misses are handled by burst fills and dirty-victim burst write-back. An explicit flush writes back all dirty lines. Only one CPU request is outstanding at a time; hits complete at full rate.

Parameters:
- DATABITS, 32, CPU/memory word width; must be 32 (byte/half/word semantics).
- ADDRBITS, 32, byte address width.
- LINENUM, 4, number of lines; power of two, ≥1.
- WORDS, 8, words per line and burst length; power of two, ≥2.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  reset; asynchronous, active-low.
- dcache_addr  in  ADDRBITS  CPU byte address.
- dcache_in  in  DATABITS  CPU write data, right-aligned.
- dcache_rdreq  in  1  read request; sampled only while dcache_ready=1.
- dcache_wrreq  in  1  write request; sampled only while dcache_ready=1.
- dcache_wordlen  in  2  00=byte, 01=half, 10=word; 11 is treated as word.
- dcache_out  out  DATABITS  read data, right-aligned, zero-extended.
- dcache_out_valid  out  1  one-cycle pulse with read data.
- dcache_ready  out  1  high in IDLE only.
- dcache_flush  in  1  request write-back of all dirty lines.
- dcache_flush_done  out  1  one-cycle pulse when the flush completes.
- mem_addr  out  ADDRBITS  line-aligned burst base address.
- mem_in  out  DATABITS  write-burst data.
- mem_wrreq  out  1  held high for the whole write burst.
- mem_wr_ack  in  1  current mem_in word accepted.
- mem_rdreq  out  1  one-cycle pulse starting a read burst.
- mem_out  in  DATABITS  read-burst data.
- mem_out_valid  in  1  one word of read data on mem_out.
- mem_burstlen  out  16  always WORDS.

Behaviour:
- Reset values: all valid and dirty bits 0; round-robin pointer 0; state IDLE. Outputs: dcache_ready=1; all request, valid and done pulses 0; mem_addr, mem_in, dcache_out all 0.
- Address split:
  - OFFS = log2(WORDS*4).
  - tag = addr[ADDRBITS-1:OFFS].
  - word index = addr[OFFS-1:2].
  - byte lane = addr[1:0]. A half access uses addr[1] and ignores addr[0].
- Hit detection is combinational: a line hits when it is valid and its tag matches. At most one line can hit.
- Read hit, request at cycle N: dcache_out_valid=1 at N+1 with the selected byte/half/word zero-extended. dcache_ready stays 1, so back-to-back hits run every cycle.
- Write hit at N: byte-enable merge into the word; dirty set; visible to a read issued at N+1. No output pulse.
- Both rdreq and wrreq high: treated as a write.
- Miss at N: latch the request; dcache_ready=0 from N+1. The victim is the line at the round-robin pointer; the pointer increments modulo LINENUM after each fill.
- State machine:
  - IDLE → EVICT if the victim is valid and dirty, else → FILL_REQ.
  - EVICT: mem_wrreq=1, mem_addr = victim base, mem_in = victim word k. k advances on mem_wr_ack. After word WORDS-1 is acked → FILL_REQ.
  - FILL_REQ: one-cycle mem_rdreq with mem_addr = request base → FILL.
  - FILL: each mem_out_valid writes word k, k+1, ...; the memory returns words in order. After the WORDS-th word, the line gets the new tag, valid=1, dirty=0 → RESPOND.
  - RESPOND: perform the latched read or write on the filled line. A read pulses dcache_out_valid in this cycle. → IDLE.
- Flush: accepted in IDLE only when no rdreq/wrreq is present; requests take priority.
  - FLUSH_SCAN visits lines 0..LINENUM-1 in order, one cycle per line.
  - Each valid, dirty line goes through FLUSH_WB, which runs the EVICT protocol and then clears dirty. Lines stay valid.
  - After the last line: dcache_flush_done pulses and the state returns to IDLE. With no dirty lines, done arrives LINENUM+1 cycles after acceptance.
- mem_out_valid outside FILL and mem_wr_ack outside EVICT/FLUSH_WB are ignored.
- Reset mid-burst: all state clears immediately; the memory controller is reset by the same reset_n.

Decomposition:
- Package dcache_pkg holds:
  - the state enum {IDLE, EVICT, FILL_REQ, FILL, RESPOND, FLUSH_SCAN, FLUSH_WB};
  - the wordlen encodings;
  - a byte-enable function from (wordlen, addr[1:0]);
  - an extract/zero-extend function.
- One sub-module, dcache_way: a single line's tag, valid, dirty and WORDS×DATABITS storage. It provides the hit compare, a byte-enabled CPU write port, a fill write port and a word read mux. It is instantiated LINENUM times with a generate loop; the FSM and round-robin pointer live in the top level.

Test Plan:
- Cold read 0x0000_0104, word → mem_rdreq with mem_addr 0x0000_0100, burst 8. Return words 0x100+i. dcache_out=0x0000_0101, one pulse.
- After that fill: byte read 0x107 → 0x00 (MSB of 0x101); half read 0x106 → 0x0000. A write word 0xDEADBEEF to 0x108 followed by a read at the next cycle → 0xDEADBEEF with no memory traffic.
- Five distinct line misses with LINENUM=4: the fifth evicts line 0. If line 0 is dirty, mem_wrreq is issued with 8 words; mem_wr_ack is delayed 3 cycles each and the data must hold meanwhile. Then the fill follows.
- Byte write 0xAA to 0x101 into word 0x11223344 → word reads 0x1122AA44.
- dcache_flush with two dirty lines → two 8-word write bursts in index order, then flush_done. A second flush produces no bursts and done after LINENUM+1 cycles.
- reset_n low during FILL word 3 → dcache_ready=1 immediately; a subsequent read of the same address misses again.
